mine_placer: RTL and testbench

- Sequences board generation for the 8x8 Minesweeper game.
- On a start request it places exactly NUM_MINES unique mines into a 64-bit mine map, driven by a 6-bit LFSR candidate generator.
- Candidates that collide with an existing mine or with the protected "safe" cell are resolved by linear probing.
- When the map is complete, it issues a one-cycle load strobe so the datapath's mine-map register (ldMM / MMin) captures the board.

---
 rtl/mine_placer.sv | 141 ++++++++++++++
 tb/tb_mine_placer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mine_placer.sv
// mine_placer
//   Builds an 8x8 Minesweeper board. An accepted start clears the map, then
//   places exactly NUM_MINES distinct mines. Candidates come from a 6-bit
//   LFSR; a candidate that hits an existing mine or the protected safe cell
//   is moved forward by linear probing. Completion is reported by a
//   one-cycle done pulse with a coincident load_mm strobe for the datapath
//   mine-map register.
//
// Ports
//   clk        in   1   system clock
//   resetn     in   1   asynchronous active-low reset
//   start      in   1   new-board request, honoured only while idle
//   seed       in   6   LFSR seed, captured on an accepted start
//   safe_en    in   1   protect safe_cell from receiving a mine
//   safe_cell  in   6   protected cell index (row*8+col)
//   busy       out  1   a board is being built (CLEAR through DONE)
//   done       out  1   one-cycle completion pulse
//   load_mm    out  1   one-cycle load strobe, coincident with done
//   mine_map   out  64  bit i set = cell i holds a mine
//   mine_count out  7   mines placed so far
module mine_placer #(
  parameter int NUM_MINES = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [5:0]  seed,
  input  logic        safe_en,
  input  logic [5:0]  safe_cell,
  output logic        busy,
  output logic        done,
  output logic        load_mm,
  output logic [63:0] mine_map,
  output logic [6:0]  mine_count
);

  // At most 63 mines fit when the safe cell may be excluded, and at least
  // one mine is needed for the completion check to be reachable.
  if (NUM_MINES < 1 || NUM_MINES > 63) begin : g_bad_num_mines
    $error("mine_placer: NUM_MINES must be in 1..63");
  end

  localparam logic [6:0] TARGET = 7'(NUM_MINES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    DRAW  = 3'd2,
    PROBE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  lfsr_q, lfsr_d;
  logic [5:0]  cand_q, cand_d;
  logic        safe_en_q, safe_en_d;
  logic [5:0]  safe_cell_q, safe_cell_d;
  logic [63:0] mine_map_q, mine_map_d;
  logic [6:0]  mine_count_q, mine_count_d;
  logic        blocked;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      lfsr_q       <= '0;
      cand_q       <= '0;
      safe_en_q    <= 1'b0;
      safe_cell_q  <= '0;
      mine_map_q   <= '0;
      mine_count_q <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      cand_q       <= cand_d;
      safe_en_q    <= safe_en_d;
      safe_cell_q  <= safe_cell_d;
      mine_map_q   <= mine_map_d;
      mine_count_q <= mine_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    cand_d       = cand_q;
    safe_en_d    = safe_en_q;
    safe_cell_d  = safe_cell_q;
    mine_map_d   = mine_map_q;
    mine_count_d = mine_count_q;
    busy         = 1'b1;
    done         = 1'b0;
    load_mm      = 1'b0;
    blocked      = mine_map_q[cand_q] || (safe_en_q && (cand_q == safe_cell_q));

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          // All-ones is the XNOR LFSR lock-up state; substitute zero.
          lfsr_d      = (seed == 6'h3F) ? 6'h00 : seed;
          safe_en_d   = safe_en;
          safe_cell_d = safe_cell;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        mine_map_d   = '0;
        mine_count_d = '0;
        state_d      = DRAW;
      end
      DRAW: begin
        cand_d  = lfsr_q;
        lfsr_d  = {lfsr_q[4:0], ~(lfsr_q[5] ^ lfsr_q[4])};
        state_d = PROBE;
      end
      PROBE: begin
        if (blocked) begin
          // 6-bit add wraps 63 back to 0.
          cand_d = cand_q + 6'd1;
        end else begin
          mine_map_d[cand_q] = 1'b1;
          mine_count_d       = mine_count_q + 7'd1;
          state_d            = (mine_count_q + 7'd1 == TARGET) ? DONE : DRAW;
        end
      end
      DONE: begin
        done    = 1'b1;
        load_mm = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign mine_map   = mine_map_q;
  assign mine_count = mine_count_q;

endmodule

// File: tb/tb_mine_placer.sv
module tb_mine_placer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [5:0]  seed;
  logic        safe_en;
  logic [5:0]  safe_cell;
  logic        st [3];
  logic        bs [3];
  logic        dn [3];
  logic        ld [3];
  logic [63:0] mm [3];
  logic [6:0]  mc [3];

  // Instance 0: 4 mines, instance 1: default 10, instance 2: full 63.
  mine_placer #(.NUM_MINES(4)) u_m4 (
    .clk(clk), .resetn(resetn), .start(st[0]), .seed(seed), .safe_en(safe_en),
    .safe_cell(safe_cell), .busy(bs[0]), .done(dn[0]), .load_mm(ld[0]),
    .mine_map(mm[0]), .mine_count(mc[0]));
  mine_placer u_m10 (
    .clk(clk), .resetn(resetn), .start(st[1]), .seed(seed), .safe_en(safe_en),
    .safe_cell(safe_cell), .busy(bs[1]), .done(dn[1]), .load_mm(ld[1]),
    .mine_map(mm[1]), .mine_count(mc[1]));
  mine_placer #(.NUM_MINES(63)) u_m63 (
    .clk(clk), .resetn(resetn), .start(st[2]), .seed(seed), .safe_en(safe_en),
    .safe_cell(safe_cell), .busy(bs[2]), .done(dn[2]), .load_mm(ld[2]),
    .mine_map(mm[2]), .mine_count(mc[2]));

  int total = 0;
  int bad   = 0;

  function automatic int mines_of(input int idx);
    return (idx == 0) ? 4 : (idx == 1) ? 10 : 63;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: draw candidates from the LFSR sequence, probe forward past
  // taken/protected cells, and count the extra probe cycles.
  task automatic model(input int n, input logic [5:0] sd, input logic se,
                       input logic [5:0] sc, output logic [63:0] map, output int lat);
    bit occ [64];
    int s, c, extra;
    foreach (occ[i]) occ[i] = 1'b0;
    s = (sd == 6'h3F) ? 0 : int'(sd);
    extra = 0;
    for (int k = 0; k < n; k++) begin
      c = s;
      s = ((s * 2) % 64) + ((((s / 32) % 2) == ((s / 16) % 2)) ? 1 : 0);
      while (occ[c] || (se && c == int'(sc))) begin
        c = (c + 1) % 64;
        extra++;
      end
      occ[c] = 1'b1;
    end
    map = '0;
    for (int i = 0; i < 64; i++) map[i] = occ[i];
    lat = 2 + 2 * n + extra;
  endtask

  // Latency counts the start-sampling edge as cycle 1; done is observed at
  // the negedge following the edge that enters DONE.
  task automatic run(input int idx, input logic [5:0] sd, input logic se,
                     input logic [5:0] sc, input int again, input string tag,
                     output logic [63:0] map, output logic [6:0] cnt,
                     output int lat, output int pulses);
    int cyc;
    @(negedge clk);
    seed = sd; safe_en = se; safe_cell = sc; st[idx] = 1'b1;
    @(posedge clk);
    cyc = 1; lat = -1; pulses = 0;
    @(negedge clk);
    st[idx] = 1'b0;
    chk({tag, " busy_after_start"}, 64'(bs[idx]), 64'd1);
    while (cyc < 5000 && lat < 0) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      st[idx] = (cyc == again);
      if (dn[idx]) begin
        lat = cyc;
        pulses++;
        chk({tag, " load_mm_with_done"}, 64'(ld[idx]), 64'd1);
      end
    end
    st[idx] = 1'b0;
    map = mm[idx];
    cnt = mc[idx];
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, cyc);
    end else begin
      @(negedge clk);
      chk({tag, " busy_after_done"}, 64'(bs[idx]), 64'd0);
      if (dn[idx]) pulses++;
      repeat (3) begin
        @(negedge clk);
        if (dn[idx]) pulses++;
      end
      chk({tag, " map_held"}, mm[idx], map);
    end
  endtask

  typedef struct {
    int          idx;
    logic [5:0]  sd;
    logic        se;
    logic [5:0]  sc;
    logic [63:0] emap;
    logic [6:0]  ecnt;
    int          elat;
  } vec_t;

  initial begin
    vec_t        tbl [4];
    logic [63:0] gmap, rmap;
    logic [6:0]  gcnt;
    int          glat, gpul, rlat, ri;
    logic [5:0]  rsd, rsc;
    logic        rse;

    foreach (st[i]) st[i] = 1'b0;
    seed = '0; safe_en = 1'b0; safe_cell = '0;
    resetn = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_map%0d", i), mm[i], 64'd0);
      chk($sformatf("rst_cnt%0d", i), 64'(mc[i]), 64'd0);
      chk($sformatf("rst_flags%0d", i), {61'd0, bs[i], dn[i], ld[i]}, 64'd0);
    end
    resetn = 1'b1;
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        chk($sformatf("idle_out%0d", i), {mm[i] ^ 64'(mc[i]), 61'd0, bs[i], dn[i], ld[i]} == '0 ? 64'd0 : 64'd1, 64'd0);
    end

    // Directed vectors; elat < 0 takes the latency from the model.
    tbl[0] = '{0, 6'd1,  1'b0, 6'd0, 64'h0000_0000_0000_808A, 7'd4,  10};
    tbl[1] = '{0, 6'd1,  1'b1, 6'd3, 64'h0000_0000_0000_8092, 7'd4,  11};
    tbl[2] = '{1, 6'd1,  1'b0, 6'd0, 64'h6880_8000_8000_808A, 7'd10, 22};
    tbl[3] = '{2, 6'h3F, 1'b1, 6'd0, 64'hFFFF_FFFF_FFFF_FFFE, 7'd63, -1};
    for (int v = 0; v < 4; v++) begin
      run(tbl[v].idx, tbl[v].sd, tbl[v].se, tbl[v].sc, 0, $sformatf("vec%0d", v),
          gmap, gcnt, glat, gpul);
      chk($sformatf("vec%0d map", v), gmap, tbl[v].emap);
      chk($sformatf("vec%0d cnt", v), 64'(gcnt), 64'(tbl[v].ecnt));
      chk($sformatf("vec%0d pulses", v), 64'(gpul), 64'd1);
      if (tbl[v].elat < 0) begin
        model(mines_of(tbl[v].idx), tbl[v].sd, tbl[v].se, tbl[v].sc, rmap, rlat);
        chk($sformatf("vec%0d lat", v), 64'(glat), 64'(rlat));
      end else begin
        chk($sformatf("vec%0d lat", v), 64'(glat), 64'(tbl[v].elat));
      end
    end

    // start while busy: second start pulsed 3 cycles in is ignored
    run(0, 6'd1, 1'b0, 6'd0, 3, "rebusy", gmap, gcnt, glat, gpul);
    chk("rebusy map", gmap, 64'h0000_0000_0000_808A);
    chk("rebusy lat", 64'(glat), 64'd10);
    chk("rebusy pulses", 64'(gpul), 64'd1);
    chk("rebusy idle", 64'(bs[0]), 64'd0);

    // Reset during PROBE
    @(negedge clk);
    seed = 6'd1; safe_en = 1'b0; st[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midrst progress", 64'(mc[0]), 64'd1);
    resetn = 1'b0;
    #1;
    chk("midrst map", mm[0], 64'd0);
    chk("midrst cnt", 64'(mc[0]), 64'd0);
    chk("midrst busy", 64'(bs[0]), 64'd0);
    gpul = 0;
    repeat (3) begin
      @(negedge clk);
      if (dn[0] || ld[0]) gpul++;
    end
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (dn[0] || ld[0]) gpul++;
    end
    chk("midrst no_done", 64'(gpul), 64'd0);
    run(0, 6'd1, 1'b0, 6'd0, 0, "postrst", gmap, gcnt, glat, gpul);
    chk("postrst map", gmap, 64'h0000_0000_0000_808A);
    chk("postrst lat", 64'(glat), 64'd10);

    // Randomized boards against the reference model
    for (int r = 0; r < 24; r++) begin
      ri  = (r % 6 == 5) ? 2 : int'($urandom_range(0, 1));
      rsd = 6'($urandom);
      rse = 1'($urandom);
      rsc = 6'($urandom);
      model(mines_of(ri), rsd, rse, rsc, rmap, rlat);
      run(ri, rsd, rse, rsc, 0, $sformatf("rnd%0d", r), gmap, gcnt, glat, gpul);
      chk($sformatf("rnd%0d map", r), gmap, rmap);
      chk($sformatf("rnd%0d cnt", r), 64'(gcnt), 64'(mines_of(ri)));
      chk($sformatf("rnd%0d lat", r), 64'(glat), 64'(rlat));
      chk($sformatf("rnd%0d pulses", r), 64'(gpul), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
